// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, d = x - y - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             borrow_in,
   output logic             ready,
   output logic [WIDTH-1:0] d,
   output logic             borrow_out,
   output logic             valid,
   input  logic             ack
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] x_sr;
   logic [WIDTH-1:0] y_sr;
   logic [WIDTH-1:0] d_shift;
   logic [CNT_W-1:0] cnt;
   logic             b;
   logic             accept;
   logic             last_bit;
   logic [1:0]       slice;

   // Full-subtractor bit slice: returns {borrow_out, difference}.
   function automatic logic [1:0] sub_slice(input logic a, input logic s, input logic bi);
      logic diff;
      logic bo;
      diff = a ^ s ^ bi;
      bo   = (~a & s) | (~(a ^ s) & bi);
      return {bo, diff};
   endfunction

   assign accept   = start && ready;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));
   assign slice    = sub_slice(x_sr[0], y_sr[0], b);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            valid = 1'b1;
            if (ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // New result bits enter from the MSB so the LSB-first stream lands in place after WIDTH shifts.
   always_comb begin
      d_shift            = d >> 1;
      d_shift[WIDTH-1]   = slice[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_sr       <= '0;
         y_sr       <= '0;
         d          <= '0;
         cnt        <= '0;
         b          <= 1'b0;
         borrow_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_sr <= x;
                  y_sr <= y;
                  b    <= borrow_in;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               x_sr <= x_sr >> 1;
               y_sr <= y_sr >> 1;
               b    <= slice[1];
               d    <= d_shift;
               cnt  <= cnt + CNT_W'(1);
               if (last_bit) begin
                  borrow_out <= slice[1];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Overflow is borrow into the MSB xor borrow out of it; visible only in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else begin
         case (state)
            IDLE:    ovf <= 1'b0;
            SHIFT:   ovf <= last_bit ? (b ^ slice[1]) : 1'b0;
            DONE:    if (ack) ovf <= 1'b0;
            default: ovf <= 1'b0;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor (WIDTH=4); ovf checks under SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] x;
   logic [3:0] y;
   logic       borrow_in;
   logic       ready;
   logic [3:0] d;
   logic       borrow_out;
   logic       valid;
   logic       ack;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .x          (x),
      .y          (y),
      .borrow_in  (borrow_in),
      .ready      (ready),
      .d          (d),
      .borrow_out (borrow_out),
      .valid      (valid),
      .ack        (ack)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf        (ovf)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands with start for one edge (the acceptance edge).
   task automatic start_op(input logic [3:0] a, input logic [3:0] s, input logic bi);
      x         = a;
      y         = s;
      borrow_in = bi;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      checks++;
      if (ready !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b valid=%b, want ready=1 valid=0", ready, valid);
      end
      checks++;
      if (d !== 4'h0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: d=%h borrow_out=%b, want 0 0", d, borrow_out);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
      end
`endif
   endtask

   task automatic test_basic();
      int lat;
      start_op(4'd5, 4'd3, 1'b0);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy: ready=%b, want 0", ready);
      end
      wait_valid(lat);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL basic_latency: %0d cycles, want 4", lat);
      end
      checks++;
      if (d !== 4'd2 || borrow_out !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: d=%h bo=%b ready=%b, want 2 0 0", d, borrow_out, ready);
      end
      do_ack();
      checks++;
      if (valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL basic_ack: valid=%b ready=%b, want 0 1", valid, ready);
      end
   endtask

   task automatic test_underflow();
      int lat;
      start_op(4'd3, 4'd5, 1'b0);
      wait_valid(lat);
      checks++;
      if (d !== 4'hE || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL underflow: d=%h bo=%b, want e 1", d, borrow_out);
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL underflow_ovf: ovf=%b, want 0", ovf);
      end
`endif
      do_ack();
   endtask

   task automatic test_borrow_in();
      int lat;
      start_op(4'd0, 4'd0, 1'b1);
      wait_valid(lat);
      checks++;
      if (d !== 4'hF || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL borrow_in_wrap: d=%h bo=%b, want f 1", d, borrow_out);
      end
      do_ack();
      start_op(4'd7, 4'd7, 1'b0);
      wait_valid(lat);
      checks++;
      if (d !== 4'h0 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL equal_ops: d=%h bo=%b, want 0 0", d, borrow_out);
      end
      do_ack();
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      int lat;
      start_op(4'h8, 4'h1, 1'b0);
      wait_valid(lat);
      checks++;
      if (d !== 4'h7 || borrow_out !== 1'b0 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_neg: d=%h bo=%b ovf=%b, want 7 0 1", d, borrow_out, ovf);
      end
      do_ack();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_idle: ovf=%b, want 0", ovf);
      end
      start_op(4'h7, 4'hF, 1'b0);
      wait_valid(lat);
      checks++;
      if (d !== 4'h8 || borrow_out !== 1'b1 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_pos: d=%h bo=%b ovf=%b, want 8 1 1", d, borrow_out, ovf);
      end
      do_ack();
   endtask
`endif

   task automatic test_ignore_start();
      int lat;
      start_op(4'd5, 4'd3, 1'b0);
      x     = 4'hF;
      y     = 4'h1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_valid(lat);
      checks++;
      if (d !== 4'd2 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: d=%h bo=%b, want 2 0", d, borrow_out);
      end
      do_ack();
      step();
      checks++;
      if (ready !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL no_queue: ready=%b valid=%b, want 1 0", ready, valid);
      end
   endtask

   task automatic test_hold();
      int lat;
      int bad;
      bad = 0;
      start_op(4'd6, 4'd1, 1'b0);
      wait_valid(lat);
      for (int i = 0; i < 10; i++) begin
         step();
         if (valid !== 1'b1 || d !== 4'd5 || borrow_out !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL hold: %0d unstable cycles, want 0 (d=%h valid=%b)", bad, d, valid);
      end
      do_ack();
   endtask

   task automatic test_ack_start();
      int lat;
      int bad;
      bad = 0;
      start_op(4'd9, 4'd2, 1'b0);
      wait_valid(lat);
      x     = 4'd1;
      y     = 4'd1;
      ack   = 1'b1;
      start = 1'b1;
      step();
      ack   = 1'b0;
      start = 1'b0;
      checks++;
      if (valid !== 1'b0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL ack_start: valid=%b ready=%b, want 0 1", valid, ready);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         if (valid !== 1'b0 || ready !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL ack_start_idle: %0d busy cycles, want 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      start_op(4'd9, 4'd2, 1'b0);
      wait_valid(lat);
      do_ack();
      start_op(4'd2, 4'd9, 1'b1);
      wait_valid(lat);
      checks++;
      if (lat !== 4 || d !== 4'h8 || borrow_out !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back: lat=%0d d=%h bo=%b, want 4 8 1", lat, d, borrow_out);
      end
      do_ack();
   endtask

   task automatic test_reset_mid();
      int lat;
      start_op(4'd12, 4'd3, 1'b0);
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (valid !== 1'b0 || d !== 4'h0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: valid=%b d=%h ready=%b, want 0 0 1", valid, d, ready);
      end
      start_op(4'd9, 4'd4, 1'b0);
      wait_valid(lat);
      checks++;
      if (lat !== 4 || d !== 4'd5 || borrow_out !== 1'b0) begin
         errors++;
         $display("FAIL after_reset: lat=%0d d=%h bo=%b, want 4 5 0", lat, d, borrow_out);
      end
      do_ack();
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      x         = 4'h0;
      y         = 4'h0;
      borrow_in = 1'b0;
      ack       = 1'b0;
      test_reset();
      test_basic();
      test_underflow();
      test_borrow_in();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      test_ignore_start();
      test_hold();
      test_ack_start();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
